// File: rtl/affine_sbmv_gen.sv
// Affine subblock MV generator: derives one rounded MV per 4x4 subblock of a PU
// from its control-point MVs and streams them in raster order over valid/ready.
module affine_sbmv_gen (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                affine_6param,
    input  logic [8:0]          Ipu_w,
    input  logic [8:0]          Ipu_h,
    input  logic signed [12:0]  mvLT_x,
    input  logic signed [12:0]  mvLT_y,
    input  logic signed [12:0]  mvRT_x,
    input  logic signed [12:0]  mvRT_y,
    input  logic signed [12:0]  mvLB_x,
    input  logic signed [12:0]  mvLB_y,
    output logic                busy,
    output logic                sb_valid,
    input  logic                sb_ready,
    output logic [4:0]          sb_x,
    output logic [4:0]          sb_y,
    output logic signed [12:0]  sb_mv_x,
    output logic signed [12:0]  sb_mv_y,
    output logic                sb_last,
    output logic                done,
    output logic                err
);

    localparam int unsigned MV_W  = 13;
    localparam int unsigned SZ_W  = 9;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned ACC_W = 28;
    localparam int unsigned FRAC  = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STREAM = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t state, state_d;

    // request captured in IDLE
    logic                    six_r;
    logic [SZ_W-1:0]         w_r, h_r;
    logic signed [MV_W-1:0]  lt_x, lt_y, rt_x, rt_y, lb_x, lb_y;

    // per-PU steps and running accumulators (values are MV << 7)
    logic signed [ACC_W-1:0] hx4, hy4, vx4, vy4, row_x, row_y, acc_x, acc_y;
    logic signed [ACC_W-1:0] hx4_d, hy4_d, vx4_d, vy4_d, row_x_d, row_y_d, acc_x_d, acc_y_d;
    logic [IDX_W-1:0]        wmax, hmax, wmax_d, hmax_d;

    logic                    busy_d, valid_d, last_d, done_d, err_d;
    logic [IDX_W-1:0]        x_d, y_d;
    logic signed [MV_W-1:0]  mvx_d, mvy_d;

    logic [2:0]              lw, lh, sh_w, sh_h;
    logic                    size_ok;
    logic signed [ACC_W-1:0] dhx, dhy, dvx, dvy, base_x, base_y;

    // log2 of a legal PU dimension, 0 when the size is not a power of two in 8..128
    function automatic logic [2:0] size_log2(input logic [SZ_W-1:0] s);
        case (s)
            9'd8:    size_log2 = 3'd3;
            9'd16:   size_log2 = 3'd4;
            9'd32:   size_log2 = 3'd5;
            9'd64:   size_log2 = 3'd6;
            9'd128:  size_log2 = 3'd7;
            default: size_log2 = 3'd0;
        endcase
    endfunction

    // round toward nearest (ties toward zero on the positive side) then clip
    function automatic logic signed [MV_W-1:0] round_mv(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] t;
        t = a + ACC_W'(64) - (a[ACC_W-1] ? ACC_W'(0) : ACC_W'(1));
        t = t >>> FRAC;
        if (t > ACC_W'(4095)) begin
            t = ACC_W'(4095);
        end else if (t < ACC_W'(-4096)) begin
            t = ACC_W'(-4096);
        end
        round_mv = MV_W'(t);
    endfunction

    // SETUP arithmetic: gradients and the MV at the centre of subblock (0,0)
    always_comb begin
        lw      = size_log2(w_r);
        lh      = size_log2(h_r);
        size_ok = (lw != 3'd0) && (lh != 3'd0);
        sh_w    = 3'd7 - lw;
        sh_h    = 3'd7 - lh;
        dhx     = (ACC_W'(rt_x) - ACC_W'(lt_x)) <<< sh_w;
        dhy     = (ACC_W'(rt_y) - ACC_W'(lt_y)) <<< sh_w;
        if (six_r) begin
            dvx = (ACC_W'(lb_x) - ACC_W'(lt_x)) <<< sh_h;
            dvy = (ACC_W'(lb_y) - ACC_W'(lt_y)) <<< sh_h;
        end else begin
            dvx = -dhy;
            dvy = dhx;
        end
        base_x = (ACC_W'(lt_x) <<< FRAC) + (dhx <<< 1) + (dvx <<< 1);
        base_y = (ACC_W'(lt_y) <<< FRAC) + (dhy <<< 1) + (dvy <<< 1);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   state_d = size_ok ? STREAM : FIN;
            STREAM:  if (sb_ready && sb_last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // next values of the registered outputs and datapath
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        valid_d = sb_valid;
        x_d     = sb_x;
        y_d     = sb_y;
        mvx_d   = sb_mv_x;
        mvy_d   = sb_mv_y;
        last_d  = sb_last;
        hx4_d   = hx4;
        hy4_d   = hy4;
        vx4_d   = vx4;
        vy4_d   = vy4;
        row_x_d = row_x;
        row_y_d = row_y;
        acc_x_d = acc_x;
        acc_y_d = acc_y;
        wmax_d  = wmax;
        hmax_d  = hmax;
        case (state)
            IDLE: busy_d = start;
            SETUP: begin
                if (size_ok) begin
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    hx4_d   = dhx <<< 2;
                    hy4_d   = dhy <<< 2;
                    vx4_d   = dvx <<< 2;
                    vy4_d   = dvy <<< 2;
                    row_x_d = base_x;
                    row_y_d = base_y;
                    acc_x_d = base_x;
                    acc_y_d = base_y;
                    wmax_d  = IDX_W'((w_r >> 2) - SZ_W'(1));
                    hmax_d  = IDX_W'((h_r >> 2) - SZ_W'(1));
                    mvx_d   = round_mv(base_x);
                    mvy_d   = round_mv(base_y);
                    last_d  = 1'b0;  // smallest legal PU has 2x2 subblocks
                end else begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                end
            end
            STREAM: begin
                busy_d = 1'b1;
                if (sb_ready) begin
                    if (sb_last) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                        x_d     = '0;
                        y_d     = '0;
                        mvx_d   = '0;
                        mvy_d   = '0;
                        last_d  = 1'b0;
                    end else begin
                        if (sb_x == wmax) begin
                            row_x_d = row_x + vx4;
                            row_y_d = row_y + vy4;
                            acc_x_d = row_x_d;
                            acc_y_d = row_y_d;
                            x_d     = '0;
                            y_d     = sb_y + IDX_W'(1);
                        end else begin
                            acc_x_d = acc_x + hx4;
                            acc_y_d = acc_y + hy4;
                            x_d     = sb_x + IDX_W'(1);
                        end
                        mvx_d  = round_mv(acc_x_d);
                        mvy_d  = round_mv(acc_y_d);
                        last_d = (x_d == wmax) && (y_d == hmax);
                    end
                end
            end
            default: valid_d = 1'b0;
        endcase
    end

    // output and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            sb_valid <= 1'b0;
            sb_x     <= '0;
            sb_y     <= '0;
            sb_mv_x  <= '0;
            sb_mv_y  <= '0;
            sb_last  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            hx4      <= '0;
            hy4      <= '0;
            vx4      <= '0;
            vy4      <= '0;
            row_x    <= '0;
            row_y    <= '0;
            acc_x    <= '0;
            acc_y    <= '0;
            wmax     <= '0;
            hmax     <= '0;
        end else begin
            busy     <= busy_d;
            sb_valid <= valid_d;
            sb_x     <= x_d;
            sb_y     <= y_d;
            sb_mv_x  <= mvx_d;
            sb_mv_y  <= mvy_d;
            sb_last  <= last_d;
            done     <= done_d;
            err      <= err_d;
            hx4      <= hx4_d;
            hy4      <= hy4_d;
            vx4      <= vx4_d;
            vy4      <= vy4_d;
            row_x    <= row_x_d;
            row_y    <= row_y_d;
            acc_x    <= acc_x_d;
            acc_y    <= acc_y_d;
            wmax     <= wmax_d;
            hmax     <= hmax_d;
        end
    end

    // request capture, only when a start is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            six_r <= 1'b0;
            w_r   <= '0;
            h_r   <= '0;
            lt_x  <= '0;
            lt_y  <= '0;
            rt_x  <= '0;
            rt_y  <= '0;
            lb_x  <= '0;
            lb_y  <= '0;
        end else if (state == IDLE && start) begin
            six_r <= affine_6param;
            w_r   <= Ipu_w;
            h_r   <= Ipu_h;
            lt_x  <= mvLT_x;
            lt_y  <= mvLT_y;
            rt_x  <= mvRT_x;
            rt_y  <= mvRT_y;
            lb_x  <= mvLB_x;
            lb_y  <= mvLB_y;
        end
    end

endmodule

// File: tb/tb_affine_sbmv_gen.sv
// Bench for affine_sbmv_gen: directed and random PUs checked beat by beat
// against a closed-form (multiply-based) model of the subblock MV field.
`timescale 1ns/1ps
module tb_affine_sbmv_gen;

    logic               clk = 1'b0;
    logic               rst, start, affine_6param, sb_ready;
    logic [8:0]         Ipu_w, Ipu_h;
    logic signed [12:0] mvLT_x, mvLT_y, mvRT_x, mvRT_y, mvLB_x, mvLB_y;
    logic               busy, sb_valid, sb_last, done, err;
    logic [4:0]         sb_x, sb_y;
    logic signed [12:0] sb_mv_x, sb_mv_y;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_x[$], exp_y[$], exp_mx[$], exp_my[$];
    bit exp_legal;

    affine_sbmv_gen dut (
        .clk(clk), .rst(rst), .start(start), .affine_6param(affine_6param),
        .Ipu_w(Ipu_w), .Ipu_h(Ipu_h),
        .mvLT_x(mvLT_x), .mvLT_y(mvLT_y), .mvRT_x(mvRT_x), .mvRT_y(mvRT_y),
        .mvLB_x(mvLB_x), .mvLB_y(mvLB_y),
        .busy(busy), .sb_valid(sb_valid), .sb_ready(sb_ready),
        .sb_x(sb_x), .sb_y(sb_y), .sb_mv_x(sb_mv_x), .sb_mv_y(sb_mv_y),
        .sb_last(sb_last), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string grp, input string tag, input logic signed [31:0] obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0d, expected %0d", grp, tag, obs, expv);
        end
    endtask

    function automatic int log2_legal(input int s);
        for (int k = 3; k <= 7; k++) if (s == (1 << k)) return k;
        return -1;
    endfunction

    function automatic int round_clip(input int a);
        int v;
        v = (a + 64 - ((a >= 0) ? 1 : 0)) >>> 7;
        if (v > 4095) v = 4095;
        if (v < -4096) v = -4096;
        return v;
    endfunction

    // closed-form MV field evaluated at every subblock centre
    task automatic build_model(input int w, input int h, input bit six,
                               input int ltx, input int lty, input int rtx, input int rty,
                               input int lbx, input int lby);
        int lw, lh, dhx, dhy, dvx, dvy, cx, cy;
        exp_x.delete(); exp_y.delete(); exp_mx.delete(); exp_my.delete();
        lw = log2_legal(w);
        lh = log2_legal(h);
        exp_legal = (lw >= 0) && (lh >= 0);
        if (!exp_legal) return;
        dhx = (rtx - ltx) * (1 << (7 - lw));
        dhy = (rty - lty) * (1 << (7 - lw));
        if (six) begin
            dvx = (lbx - ltx) * (1 << (7 - lh));
            dvy = (lby - lty) * (1 << (7 - lh));
        end else begin
            dvx = -dhy;
            dvy = dhx;
        end
        for (int ys = 0; ys < h / 4; ys++) begin
            for (int xs = 0; xs < w / 4; xs++) begin
                cx = 4 * xs + 2;
                cy = 4 * ys + 2;
                exp_x.push_back(xs);
                exp_y.push_back(ys);
                exp_mx.push_back(round_clip(ltx * 128 + dhx * cx + dvx * cy));
                exp_my.push_back(round_clip(lty * 128 + dhy * cx + dvy * cy));
            end
        end
    endtask

    // mode: 0 ready high, 1 three-cycle stall then toggle, 2 random ready
    task automatic run_pu(input string name, input int w, input int h, input bit six,
                          input int ltx, input int lty, input int rtx, input int rty,
                          input int lbx, input int lby,
                          input int mode, input int rst_beat, input bit noise);
        int n, beat, cyc, limit, k;
        bit rdy, stalled;
        logic [4:0] px, py;
        logic signed [12:0] pmx, pmy;
        logic plast;
        build_model(w, h, six, ltx, lty, rtx, rty, lbx, lby);
        n = exp_x.size();
        Ipu_w = 9'(w); Ipu_h = 9'(h); affine_6param = six;
        mvLT_x = 13'(ltx); mvLT_y = 13'(lty); mvRT_x = 13'(rtx);
        mvRT_y = 13'(rty); mvLB_x = 13'(lbx); mvLB_y = 13'(lby);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check(name, "busy_setup", 32'(busy), 1);
        check(name, "valid_setup", 32'(sb_valid), 0);
        @(posedge clk); #1;
        if (!exp_legal) begin
            check(name, "err_done", 32'(done), 1);
            check(name, "err_err", 32'(err), 1);
            check(name, "err_valid", 32'(sb_valid), 0);
            check(name, "err_busy", 32'(busy), 0);
            @(posedge clk); #1;
            check(name, "err_done_clr", 32'(done), 0);
            check(name, "err_err_clr", 32'(err), 0);
            check(name, "err_valid_clr", 32'(sb_valid), 0);
            return;
        end
        check(name, "first_valid", 32'(sb_valid), 1);
        beat = 0; cyc = 0; k = 0; stalled = 1'b0; limit = 4 * n + 64;
        px = '0; py = '0; pmx = '0; pmy = '0; plast = 1'b0;
        while (beat < n && cyc < limit) begin
            check(name, "valid_held", 32'(sb_valid), 1);
            check(name, "busy_stream", 32'(busy), 1);
            if (stalled) begin
                check(name, "hold_x", 32'(sb_x), int'(px));
                check(name, "hold_y", 32'(sb_y), int'(py));
                check(name, "hold_mvx", 32'(sb_mv_x), int'(pmx));
                check(name, "hold_mvy", 32'(sb_mv_y), int'(pmy));
                check(name, "hold_last", 32'(sb_last), int'(plast));
            end
            if (beat == rst_beat) begin
                rst = 1'b1; sb_ready = 1'b1; start = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                check(name, "rst_busy", 32'(busy), 0);
                check(name, "rst_valid", 32'(sb_valid), 0);
                check(name, "rst_x", 32'(sb_x), 0);
                check(name, "rst_y", 32'(sb_y), 0);
                check(name, "rst_mvx", 32'(sb_mv_x), 0);
                check(name, "rst_mvy", 32'(sb_mv_y), 0);
                check(name, "rst_last", 32'(sb_last), 0);
                check(name, "rst_done", 32'(done), 0);
                check(name, "rst_err", 32'(err), 0);
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k >= 3) && ((k - 3) % 2 == 0);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            sb_ready = rdy;
            if (rdy && sb_valid) begin
                check(name, "sb_x", 32'(sb_x), exp_x[beat]);
                check(name, "sb_y", 32'(sb_y), exp_y[beat]);
                check(name, "mv_x", 32'(sb_mv_x), exp_mx[beat]);
                check(name, "mv_y", 32'(sb_mv_y), exp_my[beat]);
                check(name, "sb_last", 32'(sb_last), (beat == n - 1) ? 1 : 0);
                beat++;
                stalled = 1'b0;
            end else begin
                stalled = sb_valid;
                px = sb_x; py = sb_y; pmx = sb_mv_x; pmy = sb_mv_y; plast = sb_last;
            end
            if (noise) begin
                start  = ($urandom_range(0, 1) == 1);
                mvLT_x = 13'($urandom); mvRT_y = 13'($urandom); mvLB_x = 13'($urandom);
                Ipu_w  = 9'($urandom);
            end
            k++;
            @(posedge clk); #1;
            cyc++;
        end
        check(name, "beats_accepted", beat, n);
        if (mode == 0) check(name, "one_beat_per_cycle", cyc, n);
        start = noise;
        check(name, "done_pulse", 32'(done), 1);
        check(name, "done_err", 32'(err), 0);
        check(name, "fin_busy", 32'(busy), 0);
        check(name, "fin_valid", 32'(sb_valid), 0);
        @(posedge clk); #1;
        start = 1'b0;
        check(name, "done_clr", 32'(done), 0);
        check(name, "idle_busy", 32'(busy), 0);
    endtask

    function automatic int rmv();
        return int'($urandom_range(0, 8191)) - 4096;
    endfunction

    initial begin
        int sizes[5];
        sizes[0] = 8; sizes[1] = 16; sizes[2] = 32; sizes[3] = 64; sizes[4] = 128;
        rst = 1'b1; start = 1'b0; sb_ready = 1'b0; affine_6param = 1'b0;
        Ipu_w = '0; Ipu_h = '0;
        mvLT_x = '0; mvLT_y = '0; mvRT_x = '0; mvRT_y = '0; mvLB_x = '0; mvLB_y = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", "busy", 32'(busy), 0);
        check("reset", "valid", 32'(sb_valid), 0);
        check("reset", "x", 32'(sb_x), 0);
        check("reset", "y", 32'(sb_y), 0);
        check("reset", "mvx", 32'(sb_mv_x), 0);
        check("reset", "mvy", 32'(sb_mv_y), 0);
        check("reset", "last", 32'(sb_last), 0);
        check("reset", "done", 32'(done), 0);
        check("reset", "err", 32'(err), 0);
        rst = 1'b0;

        run_pu("translate", 128, 128, 1'b0, -92, -20, -92, -20, -92, -20, 0, -1, 1'b0);
        run_pu("zoom", 16, 16, 1'b0, 0, 0, 16, 0, 0, 0, 0, -1, 1'b0);
        run_pu("neground", 8, 8, 1'b1, 0, 0, -1, 0, 0, 0, 0, -1, 1'b0);
        run_pu("clip", 8, 8, 1'b0, 4000, 0, 4000, -4000, 0, 0, 0, -1, 1'b0);
        run_pu("backpressure", 32, 16, 1'b1, rmv(), rmv(), rmv(), rmv(), rmv(), rmv(), 1, -1, 1'b0);
        run_pu("reset_mid", 32, 32, 1'b0, rmv(), rmv(), rmv(), rmv(), rmv(), rmv(), 0, 5, 1'b1);
        run_pu("fresh", 32, 32, 1'b1, rmv(), rmv(), rmv(), rmv(), rmv(), rmv(), 2, -1, 1'b1);
        run_pu("illegal", 12, 16, 1'b0, 5, 5, 9, 9, 0, 0, 0, -1, 1'b0);
        run_pu("illegal256", 256, 8, 1'b1, 5, 5, 9, 9, 0, 0, 0, -1, 1'b0);
        run_pu("illegal4", 8, 4, 1'b0, 5, 5, 9, 9, 0, 0, 0, -1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_pu("random", sizes[$urandom_range(0, 4)], sizes[$urandom_range(0, 4)],
                   ($urandom_range(0, 1) == 1), rmv(), rmv(), rmv(), rmv(), rmv(), rmv(),
                   2, -1, (i % 2 == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
